// File: rtl/cnna_udiv_seq_31ns_13ns_19.sv
// Sequential radix-2 restoring unsigned divider (din0 / din1), one quotient bit per ce edge.
// Define CNNA_UDIV_ROUND_EN for a round-half-up quotient stage (one extra cycle).
module cnna_udiv_seq_31ns_13ns_19 #(
    parameter int unsigned ID         = 1,
    parameter int unsigned din0_WIDTH = 31,
    parameter int unsigned din1_WIDTH = 13,
    parameter int unsigned dout_WIDTH = 19
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_err
);

    localparam int unsigned N     = dout_WIDTH;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned R_W   = din1_WIDTH;
    localparam int unsigned T_W   = din1_WIDTH + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef CNNA_UDIV_ROUND_EN
    localparam logic [1:0] ST_ROUND = 2'd3;
`endif

    // Instance tag stays visible in the elaborated hierarchy only.
    if (ID != 0) begin : g_tagged
    end else begin : g_untagged
    end

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [R_W-1:0]        div_q, div_d;
    logic [R_W-1:0]        part_q, part_d;
    logic [N-1:0]          shf_q, shf_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
    logic [din1_WIDTH-1:0] rem_q, rem_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;

    logic [T_W-1:0]        trial_c;
    logic                  ge_c;
    logic [R_W-1:0]        part_next_c;
    logic [N-1:0]          shf_next_c;
    logic                  accept_c;
    logic                  err_c;
`ifdef CNNA_UDIV_ROUND_EN
    logic                  rnd_up_c;
    logic [N-1:0]          q_inc_c;
`endif

    // One restoring step: shifted remainder minus divisor, quotient bit enters shf LSB.
    always_comb begin
        trial_c     = {part_q, shf_q[N-1]};
        ge_c        = trial_c >= T_W'(div_q);
        part_next_c = ge_c ? R_W'(trial_c - T_W'(div_q)) : R_W'(trial_c);
        shf_next_c  = {shf_q[N-2:0], ge_c};
        accept_c    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        err_c       = (din1 == '0) || ((din0 >> N) >= din0_WIDTH'(din1));
`ifdef CNNA_UDIV_ROUND_EN
        rnd_up_c    = {part_q, 1'b0} >= T_W'(div_q);
        q_inc_c     = (&shf_q) ? shf_q : N'(shf_q + 1'b1);
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        part_d  = part_q;
        shf_d   = shf_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_c) begin
                    div_d  = din1;
                    part_d = R_W'(din0 >> N);
                    shf_d  = din0[N-1:0];
                    cnt_d  = CNT_W'(N - 1);
                    if (err_c) begin
                        state_d = ST_DONE;
                        dout_d  = '1;
                        rem_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                part_d = part_next_c;
                shf_d  = shf_next_c;
                cnt_d  = CNT_W'(cnt_q - 1'b1);
                if (cnt_q == '0) begin
`ifdef CNNA_UDIV_ROUND_EN
                    state_d = ST_ROUND;
`else
                    state_d = ST_DONE;
                    dout_d  = shf_next_c;
                    rem_d   = part_next_c;
                    err_d   = 1'b0;
`endif
                end
            end
`ifdef CNNA_UDIV_ROUND_EN
            ST_ROUND: begin
                state_d = ST_DONE;
                dout_d  = rnd_up_c ? q_inc_c : shf_q;
                rem_d   = part_q;
                err_d   = 1'b0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    // State and output registers; ce low freezes everything.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            part_q  <= '0;
            shf_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            part_q  <= part_d;
            shf_q   <= shf_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign dout    = dout_q;
    assign rem     = rem_q;
    assign div_err = err_q;

endmodule

// File: tb/tb_cnna_udiv_seq_31ns_13ns_19.sv
// Directed bench for cnna_udiv_seq_31ns_13ns_19: latency, results, errors, ce, reset, back-to-back.
module tb_cnna_udiv_seq_31ns_13ns_19;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ce;
    logic        start;
    logic [30:0] din0;
    logic [12:0] din1;
    logic        ready;
    logic        done;
    logic [18:0] dout;
    logic [12:0] rem;
    logic        div_err;

    int total  = 0;
    int passed = 0;

`ifdef CNNA_UDIV_ROUND_EN
    localparam int LAT = 21;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 20;
    localparam bit RND = 1'b0;
`endif

    cnna_udiv_seq_31ns_13ns_19 dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ce       (ce),
        .start    (start),
        .din0     (din0),
        .din1     (din1),
        .ready    (ready),
        .done     (done),
        .dout     (dout),
        .rem      (rem),
        .div_err  (div_err)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Starts an operation from a negedge; returns at the negedge where done is first seen.
    task automatic run_op(input string tag, input logic [30:0] a, input logic [12:0] b,
                          input int exp_lat, input logic [18:0] eq, input logic [12:0] er,
                          input logic ee, input int pause_at, input int pause_len, input bit junk);
        int lat;
        bit seen;
        din0  = a;
        din1  = b;
        start = 1'b1;
        lat   = 0;
        seen  = 1'b0;
        while (!seen && lat < 80) begin
            @(posedge ap_clk);
            lat++;
            #1 start = 1'b0;
            if (junk && lat == 5) begin
                din0  = 31'h7FFF_FFFF;
                din1  = 13'd1;
                start = 1'b1;
            end
            if (pause_len > 0 && lat == pause_at) ce = 1'b0;
            if (pause_len > 0 && lat == pause_at + pause_len) ce = 1'b1;
            @(negedge ap_clk);
            seen = done;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_dout"},    32'(dout), 32'(eq));
        check({tag, "_rem"},     32'(rem), 32'(er));
        check({tag, "_err"},     32'(div_err), 32'(ee));
        check({tag, "_ready"},   32'(ready), 32'd1);
    endtask

    initial begin
        logic [30:0] ra;
        logic [12:0] rb;
        logic [18:0] rq;
        logic [12:0] rr;
        logic        re;

        ap_rst_n = 1'b0;
        ce       = 1'b1;
        start    = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (2) @(negedge ap_clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_dout",  32'(dout), 32'd0);
        check("rst_rem",   32'(rem), 32'd0);
        check("rst_err",   32'(div_err), 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        run_op("t1_1e6_by_1000", 31'd1000000, 13'd1000, LAT, 19'd1000, 13'd0, 1'b0, 0, 0, 1'b0);
        run_op("t2_7_by_2", 31'd7, 13'd2, LAT, RND ? 19'd4 : 19'd3, 13'd1, 1'b0, 0, 0, 1'b0);
        run_op("t3_div0", 31'd12345, 13'd0, 1, 19'h7FFFF, 13'd0, 1'b1, 0, 0, 1'b0);
        run_op("t3_ovf", 31'h7FFF_FFFF, 13'd1, 1, 19'h7FFFF, 13'd0, 1'b1, 0, 0, 1'b0);
        run_op("t3_ovf_edge", 31'd6815744, 13'd13, 1, 19'h7FFFF, 13'd0, 1'b1, 0, 0, 1'b0);
        run_op("t4_max_q", 31'd6815743, 13'd13, LAT, 19'd524287, 13'd12, 1'b0, 0, 0, 1'b0);
        run_op("t4_ce_pause", 31'd6815743, 13'd13, LAT + 5, 19'd524287, 13'd12, 1'b0, 6, 5, 1'b0);

        // Reset mid-calculation clears outputs at once and suppresses done.
        din0  = 31'd123456;
        din1  = 13'd77;
        start = 1'b1;
        @(posedge ap_clk);
        #1 start = 1'b0;
        repeat (7) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        check("t5_rst_dout",  32'(dout), 32'd0);
        check("t5_rst_rem",   32'(rem), 32'd0);
        check("t5_rst_done",  32'(done), 32'd0);
        check("t5_rst_ready", 32'(ready), 32'd1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            check("t5_no_done", 32'(done), 32'd0);
        end
        run_op("t5_100_by_7", 31'd100, 13'd7, LAT, 19'd14, 13'd2, 1'b0, 0, 0, 1'b0);

        // Back-to-back start in the DONE cycle, with a stray start during CALC.
        run_op("t6_first", 31'd1000000, 13'd1000, LAT, 19'd1000, 13'd0, 1'b0, 0, 0, 1'b0);
        run_op("t6_second", 31'd999, 13'd10, LAT, RND ? 19'd100 : 19'd99, 13'd9, 1'b0, 0, 0, 1'b1);

        // ce low in DONE: done held, start not accepted.
        ce    = 1'b0;
        din0  = 31'd50;
        din1  = 13'd5;
        start = 1'b1;
        repeat (3) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            check("t7_ce0_done", 32'(done), 32'd1);
            check("t7_ce0_dout", 32'(dout), RND ? 32'd100 : 32'd99);
        end
        start = 1'b0;
        ce    = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        check("t7_idle_done",  32'(done), 32'd0);
        check("t7_idle_ready", 32'(ready), 32'd1);

        // Operands against the / and % reference.
        for (int i = 0; i < 20; i++) begin
            ra = 31'($urandom) >> $urandom_range(0, 14);
            rb = 13'($urandom_range(0, 8191));
            if (rb == 13'd0 || (ra >> 19) >= 31'(rb)) begin
                rq = 19'h7FFFF;
                rr = 13'd0;
                re = 1'b1;
            end else begin
                rq = 19'(ra / 31'(rb));
                rr = 13'(ra % 31'(rb));
                re = 1'b0;
                if (RND && (14'(rr) * 14'd2) >= 14'(rb) && rq != 19'h7FFFF) rq = rq + 19'd1;
            end
            run_op($sformatf("rnd%0d", i), ra, rb, re ? 1 : LAT, rq, rr, re, 0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
